// File: rtl/painterengine_gpu_display_fetcher.sv
// Framebuffer fetch engine for the display path.
// It walks a clipped rectangle of the framebuffer line by line and requests
// bounded DMA read bursts, waiting for room in the downstream pixel FIFO
// before each request. Frame geometry is shadowed at the start of every
// frame, so the register block can double-buffer without tearing.
module painterengine_gpu_display_fetcher #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DIM_WIDTH      = 16,
    parameter int BURST_WORDS    = 32,
    parameter int FIFO_CNT_WIDTH = 9
) (
    input  logic                      i_wire_clock,
    input  logic                      i_wire_reset,
    input  logic                      i_wire_start,
    input  logic                      i_wire_stop,
    input  logic                      i_wire_continuous,
    input  logic [ADDR_WIDTH-1:0]     i_wire_image_address,
    input  logic [ADDR_WIDTH-1:0]     i_wire_image_stride,
    input  logic [DIM_WIDTH-1:0]      i_wire_clip_width,
    input  logic [DIM_WIDTH-1:0]      i_wire_clip_height,
    input  logic [1:0]                i_wire_bpp_log2,
    input  logic [FIFO_CNT_WIDTH-1:0] i_wire_fifo_free,
    output logic [ADDR_WIDTH-1:0]     o_wire_reader_address,
    output logic [31:0]               o_wire_reader_length,
    output logic                      o_wire_reader_start,
    input  logic                      i_wire_reader_done,
    input  logic                      i_wire_reader_error,
    output logic                      o_wire_busy,
    output logic                      o_wire_frame_done,
    output logic                      o_wire_error,
    output logic [2:0]                o_wire_state,
    output logic [DIM_WIDTH-1:0]      o_wire_line,
    output logic [15:0]               o_wire_frame_count
);

    // Byte offsets within a line need two extra bits for 4-byte pixels.
    localparam int          XW          = DIM_WIDTH + 2;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_WORDS * 4);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LATCH      = 3'd1,
        CALC       = 3'd2,
        WAIT_SPACE = 3'd3,
        ISSUE      = 3'd4,
        WAIT_DONE  = 3'd5,
        ADVANCE    = 3'd6,
        ERROR      = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] lineBase_q, lineBase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DIM_WIDTH-1:0]  width_q, width_d;
    logic [DIM_WIDTH-1:0]  height_q, height_d;
    logic [DIM_WIDTH-1:0]  line_q, line_d;
    logic [1:0]            bpp_q, bpp_d;
    logic [XW-1:0]         xBytes_q, xBytes_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           words_q, words_d;
    logic                  error_q, error_d;
    logic                  frameDone_q, frameDone_d;
    logic [15:0]           frameCount_q, frameCount_d;

    logic [1:0]            bppIn;
    logic [XW-1:0]         lineBytes;
    logic [XW-1:0]         remaining;
    logic [31:0]           remaining32;
    logic [31:0]           burstLen;
    logic                  lineComplete;
    logic [DIM_WIDTH-1:0]  nextLine;
    logic                  continueFrames;
    logic                  fifoHasRoom;

    // Burst sizing and line bookkeeping derived from the frame shadows.
    assign bppIn          = (i_wire_bpp_log2 == 2'd3) ? 2'd2 : i_wire_bpp_log2;
    assign lineBytes      = {2'b00, width_q} << bpp_q;
    assign remaining      = lineBytes - xBytes_q;
    assign remaining32    = 32'(remaining);
    assign burstLen       = (remaining32 > BURST_BYTES) ? BURST_BYTES : remaining32;
    assign lineComplete   = (xBytes_q == lineBytes);
    assign nextLine       = line_q + DIM_WIDTH'(1);
    assign continueFrames = i_wire_continuous && !i_wire_stop;
    assign fifoHasRoom    = (32'(i_wire_fifo_free) >= words_q);

    // State and datapath registers; reset returns everything to IDLE with cleared shadows.
    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state_q      <= IDLE;
            stride_q     <= '0;
            lineBase_q   <= '0;
            addr_q       <= '0;
            width_q      <= '0;
            height_q     <= '0;
            line_q       <= '0;
            bpp_q        <= '0;
            xBytes_q     <= '0;
            len_q        <= '0;
            words_q      <= '0;
            error_q      <= 1'b0;
            frameDone_q  <= 1'b0;
            frameCount_q <= '0;
        end else begin
            state_q      <= state_d;
            stride_q     <= stride_d;
            lineBase_q   <= lineBase_d;
            addr_q       <= addr_d;
            width_q      <= width_d;
            height_q     <= height_d;
            line_q       <= line_d;
            bpp_q        <= bpp_d;
            xBytes_q     <= xBytes_d;
            len_q        <= len_d;
            words_q      <= words_d;
            error_q      <= error_d;
            frameDone_q  <= frameDone_d;
            frameCount_q <= frameCount_d;
        end
    end

    // Next-state logic: latch a frame, size each burst, wait for FIFO room, issue, then step.
    always_comb begin
        state_d      = state_q;
        stride_d     = stride_q;
        lineBase_d   = lineBase_q;
        addr_d       = addr_q;
        width_d      = width_q;
        height_d     = height_q;
        line_d       = line_q;
        bpp_d        = bpp_q;
        xBytes_d     = xBytes_q;
        len_d        = len_q;
        words_d      = words_q;
        error_d      = error_q;
        frameDone_d  = 1'b0;
        frameCount_d = frameCount_q;

        case (state_q)
            IDLE: begin
                if (i_wire_start) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                stride_d   = i_wire_image_stride;
                width_d    = i_wire_clip_width;
                height_d   = i_wire_clip_height;
                bpp_d      = bppIn;
                lineBase_d = i_wire_image_address;
                xBytes_d   = '0;
                line_d     = '0;
                if ((i_wire_clip_width == '0) || (i_wire_clip_height == '0)) begin
                    frameDone_d  = 1'b1;
                    frameCount_d = frameCount_q + 16'd1;
                    state_d      = continueFrames ? LATCH : IDLE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                addr_d  = lineBase_q + ADDR_WIDTH'(xBytes_q);
                len_d   = burstLen;
                words_d = (burstLen + 32'd3) >> 2;
                state_d = WAIT_SPACE;
            end
            WAIT_SPACE: begin
                if (fifoHasRoom) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_wire_reader_error) begin
                    error_d = 1'b1;
                    state_d = ERROR;
                end else if (i_wire_reader_done) begin
                    xBytes_d = xBytes_q + XW'(len_q);
                    state_d  = ADVANCE;
                end
            end
            ADVANCE: begin
                if (lineComplete) begin
                    xBytes_d   = '0;
                    line_d     = nextLine;
                    lineBase_d = lineBase_q + stride_q;
                end
                if (lineComplete && (nextLine == height_q)) begin
                    frameDone_d  = 1'b1;
                    frameCount_d = frameCount_q + 16'd1;
                    state_d      = continueFrames ? LATCH : IDLE;
                end else if (i_wire_stop) begin
                    state_d = IDLE;
                end else begin
                    state_d = CALC;
                end
            end
            ERROR: begin
                if (i_wire_start) begin
                    error_d = 1'b0;
                    state_d = LATCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status and reader interface taken straight from registered state.
    assign o_wire_reader_address = addr_q;
    assign o_wire_reader_length  = len_q;
    assign o_wire_reader_start   = (state_q == ISSUE);
    assign o_wire_busy           = (state_q != IDLE) && (state_q != ERROR);
    assign o_wire_frame_done     = frameDone_q;
    assign o_wire_error          = error_q;
    assign o_wire_state          = state_q;
    assign o_wire_line           = line_q;
    assign o_wire_frame_count    = frameCount_q;

endmodule

// File: tb/tb_painterengine_gpu_display_fetcher.sv
// Bench for the display fetcher: a burst-list model of each frame, a DMA
// responder, and directed scenarios with literal expectations.
module tb_painterengine_gpu_display_fetcher;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
    } burst_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [31:0] imageAddress;
    logic [31:0] imageStride;
    logic [15:0] clipWidth;
    logic [15:0] clipHeight;
    logic [1:0]  bppLog2;
    logic [8:0]  fifoFree;
    logic [31:0] readerAddress;
    logic [31:0] readerLength;
    logic        readerStart;
    logic        readerDone;
    logic        readerError;
    logic        busy;
    logic        frameDone;
    logic        errorFlag;
    logic [2:0]  state;
    logic [15:0] line;
    logic [15:0] frameCount;

    int          tests;
    int          fails;
    int          frameDoneSeen;
    int          respBursts;
    int          errBurst;
    int          doneDelay;
    logic        outstanding;
    logic [31:0] holdA;
    logic [31:0] holdL;
    burst_t      expQ[$];
    logic [31:0] obsAddr[$];
    logic [31:0] obsLen[$];

    painterengine_gpu_display_fetcher dut (
        .i_wire_clock          (clk),
        .i_wire_reset          (reset),
        .i_wire_start          (start),
        .i_wire_stop           (stop),
        .i_wire_continuous     (continuous),
        .i_wire_image_address  (imageAddress),
        .i_wire_image_stride   (imageStride),
        .i_wire_clip_width     (clipWidth),
        .i_wire_clip_height    (clipHeight),
        .i_wire_bpp_log2       (bppLog2),
        .i_wire_fifo_free      (fifoFree),
        .o_wire_reader_address (readerAddress),
        .o_wire_reader_length  (readerLength),
        .o_wire_reader_start   (readerStart),
        .i_wire_reader_done    (readerDone),
        .i_wire_reader_error   (readerError),
        .o_wire_busy           (busy),
        .o_wire_frame_done     (frameDone),
        .o_wire_error          (errorFlag),
        .o_wire_state          (state),
        .o_wire_line           (line),
        .o_wire_frame_count    (frameCount)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Model: the burst list a whole frame must produce, from geometry alone.
    task automatic expectFrame(input logic [31:0] base, input logic [31:0] stride,
                               input int width, input int height, input int bpp);
        int     lineBytes;
        burst_t b;
        lineBytes = width << ((bpp == 3) ? 2 : bpp);
        for (int ln = 0; ln < height; ln++) begin
            for (int x = 0; x < lineBytes; x += 128) begin
                b.addr = base + 32'(ln) * stride + 32'(x);
                b.len  = ((lineBytes - x) > 128) ? 32'd128 : 32'(lineBytes - x);
                expQ.push_back(b);
            end
        end
    endtask

    function automatic logic [31:0] obsA(input int i);
        return (obsAddr.size() > i) ? obsAddr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] obsL(input int i);
        return (obsLen.size() > i) ? obsLen[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] stride, input logic [15:0] width,
                                 input logic [15:0] height, input logic [1:0] bpp, input logic cont);
        imageAddress = addr;
        imageStride  = stride;
        clipWidth    = width;
        clipHeight   = height;
        bppLog2      = bpp;
        continuous   = cont;
    endtask

    task automatic pulseStart();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_start", 32'(readerStart), 32'd0);
        checkOutput("reset_error", 32'(errorFlag), 32'd0);
        checkOutput("reset_frame_count", 32'(frameCount), 32'd0);
        checkOutput("reset_address", readerAddress, 32'd0);
        checkOutput("reset_length", readerLength, 32'd0);
        checkOutput("reset_line_done", {15'd0, line, frameDone}, 32'd0);
        reset = 1'b0;
        expQ.delete();
        obsAddr.delete();
        obsLen.delete();
        frameDoneSeen = 0;
        respBursts    = 0;
        errBurst      = -1;
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((state != 3'd0) && (n < maxCycles));
        checkOutput(name, 32'(state), 32'd0);
    endtask

    task automatic waitObs(input string name, input int count, input int maxCycles);
        int n;
        n = 0;
        while ((obsAddr.size() < count) && (n < maxCycles)) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(obsAddr.size() >= count), 32'd1);
    endtask

    // Everything runs from this block: the compare process, the DMA responder and the scenarios.
    initial begin
        tests = 0; fails = 0; frameDoneSeen = 0; respBursts = 0; errBurst = -1; doneDelay = 2;
        outstanding = 1'b0; holdA = '0; holdL = '0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; readerDone = 1'b0; readerError = 1'b0;
        fifoFree = 9'd511;
        applyStimulus(32'h0, 32'h0, 16'd0, 16'd0, 2'd0, 1'b0);

        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    outstanding = 1'b0;
                end else begin
                    if (outstanding) begin
                        tests++;
                        if ((readerAddress !== holdA) || (readerLength !== holdL)) begin
                            fails++;
                            $display("[TB] FAIL burst_stable actual=0x%0h/%0d required=0x%0h/%0d",
                                     readerAddress, readerLength, holdA, holdL);
                        end
                        if (readerDone || readerError) outstanding = 1'b0;
                    end
                    if (readerStart) begin
                        burst_t e;
                        tests++;
                        if (expQ.size() == 0) begin
                            fails++;
                            $display("[TB] FAIL unexpected_start actual=0x%0h/%0d required=no request",
                                     readerAddress, readerLength);
                        end else begin
                            e = expQ.pop_front();
                            if ((readerAddress !== e.addr) || (readerLength !== e.len)) begin
                                fails++;
                                $display("[TB] FAIL burst actual=0x%0h/%0d required=0x%0h/%0d",
                                         readerAddress, readerLength, e.addr, e.len);
                            end
                        end
                        tests++;
                        if (32'(fifoFree) < ((readerLength + 32'd3) >> 2)) begin
                            fails++;
                            $display("[TB] FAIL fifo_space actual=%0d required>=%0d",
                                     fifoFree, (readerLength + 32'd3) >> 2);
                        end
                        obsAddr.push_back(readerAddress);
                        obsLen.push_back(readerLength);
                        outstanding = 1'b1;
                        holdA = readerAddress;
                        holdL = readerLength;
                    end
                    if (frameDone) frameDoneSeen++;
                end
            end
            forever begin
                @(negedge clk);
                if (readerStart && !reset) begin
                    int idx;
                    idx = respBursts;
                    respBursts++;
                    repeat (doneDelay) @(posedge clk);
                    #1;
                    readerDone  = 1'b1;
                    readerError = (idx == errBurst);
                    @(posedge clk); #1;
                    readerDone  = 1'b0;
                    readerError = 1'b0;
                end
            end
        join_none

        // Two-line frame at 4 bytes/pixel, with start-to-request latency pinned.
        doReset();
        applyStimulus(32'h1000, 32'd256, 16'd64, 16'd2, 2'd2, 1'b0);
        expectFrame(32'h1000, 32'd256, 64, 2, 2);
        pulseStart();
        checkOutput("t1_latch_state", 32'(state), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t1_start_latency", 32'(readerStart), 32'd1);
        waitIdle("t1_idle", 400);
        checkOutput("t1_burst_count", 32'(obsAddr.size()), 32'd4);
        checkOutput("t1_first_addr", obsA(0), 32'h1000);
        checkOutput("t1_second_addr", obsA(1), 32'h1080);
        checkOutput("t1_last_addr", obsA(3), 32'h1180);
        checkOutput("t1_last_len", obsL(3), 32'd128);
        checkOutput("t1_frame_done", 32'(frameDoneSeen), 32'd1);
        checkOutput("t1_frame_count", 32'(frameCount), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_model_empty", 32'(expQ.size()), 32'd0);

        // Line that is not a whole number of bursts.
        doReset();
        applyStimulus(32'h0, 32'd0, 16'd40, 16'd1, 2'd2, 1'b0);
        expectFrame(32'h0, 32'd0, 40, 1, 2);
        pulseStart();
        waitIdle("t2_idle", 200);
        checkOutput("t2_burst_count", 32'(obsAddr.size()), 32'd2);
        checkOutput("t2_second_addr", obsA(1), 32'h80);
        checkOutput("t2_tail_len", obsL(1), 32'd32);

        // Byte pixels: 10 bytes needs 3 words of FIFO room.
        doReset();
        fifoFree = 9'd2;
        applyStimulus(32'h2000, 32'd64, 16'd10, 16'd1, 2'd0, 1'b0);
        expectFrame(32'h2000, 32'd64, 10, 1, 0);
        pulseStart();
        repeat (20) @(negedge clk);
        checkOutput("t3_held_no_start", 32'(obsAddr.size()), 32'd0);
        checkOutput("t3_wait_space", 32'(state), 32'd3);
        fifoFree = 9'd3;
        waitIdle("t3_idle", 100);
        checkOutput("t3_len", obsL(0), 32'd10);
        fifoFree = 9'd511;

        // Error coincident with done on the second burst, then recovery.
        doReset();
        applyStimulus(32'h1000, 32'd256, 16'd64, 16'd2, 2'd2, 1'b0);
        expectFrame(32'h1000, 32'd256, 64, 2, 2);
        errBurst = 1;
        pulseStart();
        begin
            int n;
            n = 0;
            while ((state != 3'd7) && (n < 200)) begin
                @(negedge clk);
                n++;
            end
        end
        expQ.delete();
        checkOutput("t4_error_state", 32'(state), 32'd7);
        checkOutput("t4_error_flag", 32'(errorFlag), 32'd1);
        repeat (50) @(negedge clk);
        checkOutput("t4_no_requests", 32'(obsAddr.size()), 32'd2);
        checkOutput("t4_busy_in_error", 32'(busy), 32'd0);
        errBurst = -1;
        expectFrame(32'h1000, 32'd256, 64, 2, 2);
        pulseStart();
        checkOutput("t4_error_cleared", 32'(errorFlag), 32'd0);
        waitIdle("t4_idle", 400);
        checkOutput("t4_reissue_addr", obsA(2), 32'h1000);
        checkOutput("t4_total_bursts", 32'(obsAddr.size()), 32'd6);

        // Continuous mode with base changed mid-frame, then stop during a burst.
        doReset();
        applyStimulus(32'h1000, 32'd256, 16'd64, 16'd2, 2'd2, 1'b1);
        expectFrame(32'h1000, 32'd256, 64, 2, 2);
        expectFrame(32'h8000, 32'd256, 64, 2, 2);
        pulseStart();
        waitObs("t5_first_burst", 1, 100);
        imageAddress = 32'h8000;
        waitObs("t5_second_frame", 5, 400);
        stop = 1'b1;
        waitIdle("t5_idle", 100);
        checkOutput("t5_burst_count", 32'(obsAddr.size()), 32'd5);
        checkOutput("t5_old_frame_tail", obsA(3), 32'h1180);
        checkOutput("t5_new_frame_base", obsA(4), 32'h8000);
        checkOutput("t5_unissued", 32'(expQ.size()), 32'd3);
        checkOutput("t5_frame_count", 32'(frameCount), 32'd1);
        repeat (30) @(negedge clk);
        checkOutput("t5_stays_idle", 32'(obsAddr.size()), 32'd5);
        expQ.delete();
        stop = 1'b0;
        continuous = 1'b0;

        // Empty frame: pulse right after LATCH, no requests.
        doReset();
        applyStimulus(32'h3000, 32'd256, 16'd64, 16'd0, 2'd2, 1'b0);
        pulseStart();
        checkOutput("t6_latch_state", 32'(state), 32'd1);
        @(posedge clk); #1;
        checkOutput("t6_frame_done", 32'(frameDone), 32'd1);
        checkOutput("t6_frame_count", 32'(frameCount), 32'd1);
        checkOutput("t6_idle", 32'(state), 32'd0);
        @(posedge clk); #1;
        checkOutput("t6_pulse_single", 32'(frameDone), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("t6_no_start", 32'(obsAddr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/painterengine_gpu_display_fetcher.md
Name: painterengine_gpu_display_fetcher

Overview:
Parametrised framebuffer fetch engine for the GPU display path. It walks a clipped rectangle of a framebuffer in memory line by line and issues bounded DMA read bursts, throttled by free space in the downstream pixel FIFO. It adds several capabilities:
- selectable pixel size and arbitrary line stride;
- continuous frame looping with per-frame shadowing of the base address (double buffering);
- start/stop control, sticky error reporting and a frame counter.

It sits between the display register block and the DMA reader; the FIFO and scan-out timing are external.

Parameters:
ADDR_WIDTH, 32, width of memory addresses and stride.
DIM_WIDTH, 16, width of clip width/height and line counter.
BURST_WORDS, 32, maximum burst size in 32-bit words (power of two, 1..256).
FIFO_CNT_WIDTH, 9, width of the FIFO free-word count.

Ports:
i_wire_clock  in  1  single clock for all logic.
i_wire_reset  in  1  reset, synchronous, active-high.
i_wire_start  in  1  pulse: begin fetching; ignored unless IDLE or ERROR.
i_wire_stop  in  1  level: finish current burst, then return to IDLE.
i_wire_continuous  in  1  1 = restart automatically after each frame.
i_wire_image_address  in  ADDR_WIDTH  framebuffer base (byte address), shadowed per frame.
i_wire_image_stride  in  ADDR_WIDTH  bytes between line starts, shadowed per frame.
i_wire_clip_width  in  DIM_WIDTH  pixels per line, shadowed per frame.
i_wire_clip_height  in  DIM_WIDTH  lines per frame, shadowed per frame.
i_wire_bpp_log2  in  2  log2 bytes per pixel (0,1,2; 3 treated as 2), shadowed per frame.
i_wire_fifo_free  in  FIFO_CNT_WIDTH  free 32-bit words in the downstream FIFO.
o_wire_reader_address  out  ADDR_WIDTH  burst start byte address.
o_wire_reader_length  out  32  burst length in bytes.
o_wire_reader_start  out  1  one-cycle burst request.
i_wire_reader_done  in  1  burst complete pulse.
i_wire_reader_error  in  1  burst failed pulse.
o_wire_busy  out  1  high in every state except IDLE and ERROR.
o_wire_frame_done  out  1  one-cycle pulse at end of each frame.
o_wire_error  out  1  sticky error flag.
o_wire_state  out  3  current FSM state encoding.
o_wire_line  out  DIM_WIDTH  current line index.
o_wire_frame_count  out  16  completed frames; wraps at 65535->0.

Behaviour:
- Reset: all outputs 0, state IDLE, shadows 0.
- State encodings: IDLE=0, LATCH=1, CALC=2, WAIT_SPACE=3, ISSUE=4, WAIT_DONE=5, ADVANCE=6, ERROR=7.
- IDLE -> LATCH on i_wire_start.
- LATCH:
  - Capture address, stride, width, height and bpp into shadows.
  - Set line_base = address, x_bytes = 0, line = 0.
  - If width or height is 0: pulse frame_done, increment frame_count, then go to LATCH if continuous and not stop, else IDLE.
  - Otherwise -> CALC.
- CALC:
  - line_bytes = width << bpp.
  - remaining = line_bytes - x_bytes.
  - len = min(remaining, BURST_WORDS*4).
  - addr = line_base + x_bytes, modulo 2^ADDR_WIDTH.
  - words = (len+3)>>2.
  - -> WAIT_SPACE.
- WAIT_SPACE: hold until fifo_free >= words, then -> ISSUE. No timeout.
- ISSUE:
  - reader_start = 1 for exactly this cycle; address and length are valid from this cycle and stable until done/error.
  - -> WAIT_DONE.
  - Latency: start sampled at edge N; reader_start is high in the cycle after edge N+3 when space is available.
- WAIT_DONE:
  - error (takes priority if coincident with done): set o_wire_error -> ERROR.
  - done: x_bytes += len -> ADVANCE.
- ADVANCE:
  - If x_bytes == line_bytes: x_bytes = 0, line += 1, line_base += stride (wraps).
  - If the line reached height: frame_done pulse, frame_count += 1, then -> LATCH if continuous and not stop, else IDLE.
  - Else if stop -> IDLE.
  - Else -> CALC.
- Stop: never aborts an issued burst; it is sampled only in ADVANCE and LATCH.
- Input changes mid-frame have no effect until the next LATCH.
- ERROR: no further requests. i_wire_start clears o_wire_error and -> LATCH. Reader error outside WAIT_DONE is ignored.
- Done outside WAIT_DONE is ignored.
- Reset mid-burst: immediate return to IDLE; the DMA must be reset by the same signal.

Test Plan:
1. base 0x1000, stride 256, width 64, height 2, bpp 2, continuous 0, fifo_free 511 -> bursts (0x1000,128), (0x1080,128), (0x1100,128), (0x1180,128); one frame_done; frame_count 1; IDLE; busy 0.
2. width 40, height 1, bpp 2, base 0 -> bursts (0x0,128), (0x80,32).
3. width 10, bpp 0 -> single burst of length 10; WAIT_SPACE exits only when fifo_free >= 3 (hold at 2 for 20 cycles: no reader_start).
4. error asserted together with done on the second burst -> o_wire_error 1, state 7, no further reader_start for 50 cycles; then start -> error 0 and first burst reissued at base.
5. continuous 1, address changed from 0x1000 to 0x8000 mid-frame -> remaining bursts of the frame stay at 0x1000; next frame starts at 0x8000; stop raised mid-burst -> that burst completes, then IDLE with no new start.
6. height 0 with continuous 0 -> frame_done one cycle after LATCH, no reader_start, frame_count 1.
